// File: rtl/run_seq_ctrl.sv
// Run sequencer: holds the core in reset until started, runs it to an end PC or a
// cycle budget, then streams a window of d_mem words out with a running checksum.
module run_seq_ctrl #(
    parameter int PC_WIDTH   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 5000,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_WORDS = 16,
    parameter int ADDR_STEP  = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   end_pc,
    input  logic [DATA_W-1:0]     expected_sum,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_raddr,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  cpu_rst_n,
    output logic                  cpu_hold,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_raddr,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status,
    output logic [CNT_W-1:0]      cycles,
    output logic [DATA_W-1:0]     checksum,
    output logic                  pass
);

    localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(DUMP_WORDS - 1);
    localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]      TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(DUMP_BASE);
    localparam logic [ADDR_WIDTH-1:0] STEP_A    = ADDR_WIDTH'(ADDR_STEP);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_END_PC  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_D_ADDR,
        S_D_WAIT,
        S_D_OUT,
        S_DONE
    } state_t;

    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      cycles_q,    cycles_d;
    logic [1:0]            status_q,    status_d;
    logic [DATA_W-1:0]     checksum_q,  checksum_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [LAT_W-1:0]      lat_q,       lat_d;
    logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0]     dump_data_q, dump_data_d;
    logic [CNT_W-1:0]      cnt_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Address arithmetic is done at ADDR_WIDTH so the dump window wraps.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] idx);
        return BASE_A + ADDR_WIDTH'(idx) * STEP_A;
    endfunction

    assign cnt_inc = sat_inc(cycles_q);

    always_comb begin
        state_d     = state_q;
        cycles_d    = cycles_q;
        status_d    = status_q;
        checksum_d  = checksum_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    cycles_d   = '0;
                    status_d   = ST_NONE;
                    checksum_d = '0;
                    idx_d      = '0;
                end
            end
            S_RUN: begin
                cycles_d = cnt_inc;
                // End-PC match has priority over an expiring budget.
                if (pc == end_pc) begin
                    status_d = ST_END_PC;
                    state_d  = S_D_ADDR;
                end else if (cnt_inc >= TIMEOUT_C) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_D_ADDR;
                end
            end
            S_D_ADDR: begin
                dump_addr_d = word_addr(idx_q);
                lat_d       = '0;
                state_d     = S_D_WAIT;
            end
            S_D_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    dump_data_d = dmem_rdata;
                    state_d     = S_D_OUT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_D_OUT: begin
                if (dump_ready) begin
                    checksum_d = checksum_q + dump_data_q;
                    idx_d      = idx_q + 1'b1;
                    state_d    = (idx_q == IDX_LAST) ? S_DONE : S_D_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cycles_q    <= '0;
            status_q    <= ST_NONE;
            checksum_q  <= '0;
            idx_q       <= '0;
            lat_q       <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cycles_q    <= cycles_d;
            status_q    <= status_d;
            checksum_q  <= checksum_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
        end
    end

    // Core reset is released once started and only re-asserted in IDLE or for
    // the single restart cycle out of DONE, so core state survives for inspection.
    always_comb begin
        cpu_rst_n  = 1'b1;
        cpu_hold   = 1'b1;
        dmem_we    = 1'b0;
        dmem_raddr = cpu_raddr;
        busy       = 1'b0;
        done       = 1'b0;
        dump_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                cpu_rst_n = 1'b0;
            end
            S_RUN: begin
                cpu_hold = 1'b0;
                dmem_we  = cpu_we;
                busy     = 1'b1;
            end
            S_D_ADDR: begin
                dmem_raddr = word_addr(idx_q);
                busy       = 1'b1;
            end
            S_D_WAIT: begin
                dmem_raddr = dump_addr_q;
                busy       = 1'b1;
            end
            S_D_OUT: begin
                dmem_raddr = dump_addr_q;
                busy       = 1'b1;
                dump_valid = 1'b1;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_rst_n = ~start;
            end
            default: begin
                cpu_rst_n = 1'b0;
            end
        endcase
    end

    assign dump_addr = dump_addr_q;
    assign dump_data = dump_data_q;
    assign status    = status_q;
    assign cycles    = cycles_q;
    assign checksum  = checksum_q;
    assign pass      = done && (status_q == ST_END_PC) && (checksum_q == expected_sum);

endmodule

// File: tb/tb_run_seq_ctrl.sv
// Directed bench for run_seq_ctrl: two instances share stimulus, one dumping from
// address 0 and one from 0xF8 to exercise address wrap.
module tb_run_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, cpu_we, dump_ready;
    logic [7:0]  end_pc, pc, cpu_raddr;
    logic [31:0] expected_sum;
    logic [31:0] mem [0:255];
    logic [31:0] rdata_a, rdata_b;

    logic        cpu_rst_n_a, cpu_hold_a, dmem_we_a, dump_valid_a, busy_a, done_a, pass_a;
    logic [7:0]  dmem_raddr_a, dump_addr_a;
    logic [31:0] dump_data_a, cycles_a, checksum_a;
    logic [1:0]  status_a;

    logic        cpu_rst_n_b, cpu_hold_b, dmem_we_b, dump_valid_b, busy_b, done_b, pass_b;
    logic [7:0]  dmem_raddr_b, dump_addr_b;
    logic [31:0] dump_data_b, cycles_b, checksum_b;
    logic [1:0]  status_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    run_seq_ctrl #(.TIMEOUT(50), .DUMP_BASE(0), .DUMP_WORDS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .end_pc(end_pc), .expected_sum(expected_sum),
        .pc(pc), .cpu_we(cpu_we), .cpu_raddr(cpu_raddr), .dmem_rdata(rdata_a),
        .cpu_rst_n(cpu_rst_n_a), .cpu_hold(cpu_hold_a), .dmem_we(dmem_we_a), .dmem_raddr(dmem_raddr_a),
        .dump_valid(dump_valid_a), .dump_ready(dump_ready), .dump_addr(dump_addr_a), .dump_data(dump_data_a),
        .busy(busy_a), .done(done_a), .status(status_a), .cycles(cycles_a), .checksum(checksum_a), .pass(pass_a)
    );

    run_seq_ctrl #(.TIMEOUT(50), .DUMP_BASE(8'hF8), .DUMP_WORDS(4)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .end_pc(end_pc), .expected_sum(expected_sum),
        .pc(pc), .cpu_we(cpu_we), .cpu_raddr(cpu_raddr), .dmem_rdata(rdata_b),
        .cpu_rst_n(cpu_rst_n_b), .cpu_hold(cpu_hold_b), .dmem_we(dmem_we_b), .dmem_raddr(dmem_raddr_b),
        .dump_valid(dump_valid_b), .dump_ready(dump_ready), .dump_addr(dump_addr_b), .dump_data(dump_data_b),
        .busy(busy_b), .done(done_b), .status(status_b), .cycles(cycles_b), .checksum(checksum_b), .pass(pass_b)
    );

    // Synchronous one-cycle-latency d_mem read ports.
    always @(posedge clk) begin
        rdata_a <= mem[dmem_raddr_a];
        rdata_b <= mem[dmem_raddr_b];
    end

    // Core PC model: resets to 0, steps by 4 whenever not held.
    always @(posedge clk) begin
        if (!cpu_rst_n_a) pc <= 8'h00;
        else if (!cpu_hold_a) pc <= pc + 8'd4;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; cpu_we = 1'b0; dump_ready = 1'b0;
        end_pc = 8'h80; expected_sum = 32'd5; cpu_raddr = 8'h55;
        repeat (5) tick();
        rst_n = 1'b1;
        total++; if (checksum_a !== 32'd0) begin bad++; $display("FAIL rst_checksum got=%0h want=0", checksum_a); end
        total++; if (dump_addr_a !== 8'd0) begin bad++; $display("FAIL rst_dump_addr got=%0h want=0", dump_addr_a); end
        total++; if (dump_data_a !== 32'd0) begin bad++; $display("FAIL rst_dump_data got=%0h want=0", dump_data_a); end
        total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL rst_pass got=%0b want=0", pass_a); end
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%0b%0b want=00", busy_a, done_a); end
        for (int i = 0; i < 100; i++) begin
            tick();
            total++; if (cpu_rst_n_a !== 1'b0) begin bad++; $display("FAIL idle_cpu_rst_n cyc=%0d got=%0b want=0", i, cpu_rst_n_a); end
            total++; if (cpu_hold_a !== 1'b1) begin bad++; $display("FAIL idle_cpu_hold cyc=%0d got=%0b want=1", i, cpu_hold_a); end
            total++; if (status_a !== 2'b00) begin bad++; $display("FAIL idle_status cyc=%0d got=%0b want=00", i, status_a); end
            total++; if (cycles_a !== 32'd0) begin bad++; $display("FAIL idle_cycles cyc=%0d got=%0d want=0", i, cycles_a); end
            total++; if (dump_valid_a !== 1'b0) begin bad++; $display("FAIL idle_dump_valid cyc=%0d got=%0b want=0", i, dump_valid_a); end
        end
        total++; if (dmem_raddr_a !== 8'h55) begin bad++; $display("FAIL idle_raddr_pass got=%0h want=55", dmem_raddr_a); end
    endtask

    task automatic test_end_pc;
        int n;
        cpu_we = 1'b1; cpu_raddr = 8'h21; end_pc = 8'h80;
        #1;
        total++; if (dmem_we_a !== 1'b0) begin bad++; $display("FAIL idle_we_gate got=%0b want=0", dmem_we_a); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (cpu_hold_a !== 1'b0 || cpu_rst_n_a !== 1'b1) begin bad++; $display("FAIL run_core_ctl hold=%0b rst_n=%0b want=0,1", cpu_hold_a, cpu_rst_n_a); end
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL run_busy got=%0b want=1", busy_a); end
        total++; if (dmem_we_a !== 1'b1) begin bad++; $display("FAIL run_we_pass got=%0b want=1", dmem_we_a); end
        total++; if (dmem_raddr_a !== 8'h21) begin bad++; $display("FAIL run_raddr_pass got=%0h want=21", dmem_raddr_a); end
        n = 0;
        while (cpu_hold_a === 1'b0 && n < 200) begin tick(); n++; end
        total++; if (n !== 33) begin bad++; $display("FAIL end_run_len got=%0d want=33", n); end
        total++; if (status_a !== 2'b01) begin bad++; $display("FAIL end_status got=%0b want=01", status_a); end
        total++; if (cycles_a !== 32'd33) begin bad++; $display("FAIL end_cycles got=%0d want=33", cycles_a); end
        total++; if (dmem_we_a !== 1'b0) begin bad++; $display("FAIL end_we_gate got=%0b want=0", dmem_we_a); end
        total++; if (cpu_rst_n_a !== 1'b1) begin bad++; $display("FAIL end_cpu_rst_n got=%0b want=1", cpu_rst_n_a); end
        total++; if (dmem_raddr_a !== 8'h00) begin bad++; $display("FAIL end_dump_raddr got=%0h want=00", dmem_raddr_a); end
        total++; if (dmem_raddr_b !== 8'hF8) begin bad++; $display("FAIL end_dump_raddr_wrap got=%0h want=f8", dmem_raddr_b); end
    endtask

    task automatic test_dump;
        logic [7:0]  exp_a [4];
        logic [7:0]  exp_b [4];
        logic [31:0] exp_d [4];
        logic [7:0]  got_a [4];
        logic [7:0]  got_b [4];
        logic [31:0] got_d [4];
        int nv;
        int we_bad;
        exp_a = '{8'h00, 8'h04, 8'h08, 8'h0C};
        exp_b = '{8'hF8, 8'hFC, 8'h00, 8'h04};
        exp_d = '{32'd1, 32'd2, 32'd3, 32'hFFFFFFFF};
        got_a = '{default: 8'h00};
        got_b = '{default: 8'h00};
        got_d = '{default: 32'h0};
        dump_ready = 1'b1;
        nv = 0; we_bad = 0;
        for (int k = 0; k < 60 && done_a !== 1'b1; k++) begin
            if (dmem_we_a !== 1'b0) we_bad++;
            if (dump_valid_a === 1'b1) begin
                if (nv < 4) begin got_a[nv] = dump_addr_a; got_b[nv] = dump_addr_b; got_d[nv] = dump_data_a; end
                nv++;
            end
            tick();
        end
        dump_ready = 1'b0;
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL dump_done got=%0b want=1", done_a); end
        total++; if (nv !== 4) begin bad++; $display("FAIL dump_valid_cycles got=%0d want=4", nv); end
        total++; if (we_bad !== 0) begin bad++; $display("FAIL dump_we_gate got=%0d want=0", we_bad); end
        for (int i = 0; i < 4; i++) begin
            total++; if (got_a[i] !== exp_a[i]) begin bad++; $display("FAIL dump_addr[%0d] got=%0h want=%0h", i, got_a[i], exp_a[i]); end
            total++; if (got_b[i] !== exp_b[i]) begin bad++; $display("FAIL dump_addr_wrap[%0d] got=%0h want=%0h", i, got_b[i], exp_b[i]); end
            total++; if (got_d[i] !== exp_d[i]) begin bad++; $display("FAIL dump_data[%0d] got=%0h want=%0h", i, got_d[i], exp_d[i]); end
        end
        total++; if (checksum_a !== 32'h5) begin bad++; $display("FAIL dump_checksum got=%0h want=5", checksum_a); end
        total++; if (checksum_b !== 32'h33) begin bad++; $display("FAIL dump_checksum_wrap got=%0h want=33", checksum_b); end
        total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL dump_pass got=%0b want=1", pass_a); end
        total++; if (pass_b !== 1'b0) begin bad++; $display("FAIL dump_pass_wrap got=%0b want=0", pass_b); end
        total++; if (busy_a !== 1'b0 || cpu_hold_a !== 1'b1) begin bad++; $display("FAIL done_busy_hold got=%0b%0b want=01", busy_a, cpu_hold_a); end
        repeat (3) tick();
        total++; if (checksum_a !== 32'h5 || cycles_a !== 32'd33 || status_a !== 2'b01) begin bad++; $display("FAIL done_hold sum=%0h cyc=%0d st=%0b want=5,33,01", checksum_a, cycles_a, status_a); end
    endtask

    task automatic test_stall;
        int n;
        end_pc = 8'h80;
        start = 1'b1;
        #1;
        total++; if (cpu_rst_n_a !== 1'b0) begin bad++; $display("FAIL restart_pulse got=%0b want=0", cpu_rst_n_a); end
        tick();
        start = 1'b0;
        total++; if (cycles_a !== 32'd0 || status_a !== 2'b00 || checksum_a !== 32'd0) begin bad++; $display("FAIL restart_clear cyc=%0d st=%0b sum=%0h want=0,0,0", cycles_a, status_a, checksum_a); end
        total++; if (cpu_rst_n_a !== 1'b1 || done_a !== 1'b0) begin bad++; $display("FAIL restart_run rst_n=%0b done=%0b want=1,0", cpu_rst_n_a, done_a); end
        n = 0;
        while (cpu_hold_a === 1'b0 && n < 200) begin tick(); n++; end
        total++; if (cycles_a !== 32'd33) begin bad++; $display("FAIL stall_run_cycles got=%0d want=33", cycles_a); end
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (dump_valid_a !== 1'b1 && n < 10) begin tick(); n++; end
            if (dump_valid_a !== 1'b1) begin
                total++; bad++; $display("FAIL stall_wait_valid word=%0d got=0 want=1", w);
                break;
            end
            if (w == 2) begin
                total++; if (checksum_a !== 32'd3) begin bad++; $display("FAIL stall_pre_sum got=%0h want=3", checksum_a); end
                for (int s = 0; s < 7; s++) begin
                    tick();
                    total++; if (dump_valid_a !== 1'b1) begin bad++; $display("FAIL stall_valid s=%0d got=0 want=1", s); end
                    total++; if (dump_addr_a !== 8'h08) begin bad++; $display("FAIL stall_addr s=%0d got=%0h want=8", s, dump_addr_a); end
                    total++; if (dump_data_a !== 32'd3) begin bad++; $display("FAIL stall_data s=%0d got=%0h want=3", s, dump_data_a); end
                    total++; if (checksum_a !== 32'd3) begin bad++; $display("FAIL stall_sum s=%0d got=%0h want=3", s, checksum_a); end
                end
                dump_ready = 1'b1;
                tick();
                dump_ready = 1'b0;
                total++; if (dump_valid_a !== 1'b0) begin bad++; $display("FAIL stall_valid_fall got=1 want=0"); end
                total++; if (checksum_a !== 32'd6) begin bad++; $display("FAIL stall_post_sum got=%0h want=6", checksum_a); end
            end else begin
                dump_ready = 1'b1;
                tick();
                dump_ready = 1'b0;
            end
        end
        n = 0;
        while (done_a !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (done_a !== 1'b1 || checksum_a !== 32'd5 || pass_a !== 1'b1) begin bad++; $display("FAIL stall_final done=%0b sum=%0h pass=%0b want=1,5,1", done_a, checksum_a, pass_a); end
    endtask

    task automatic test_timeout(input logic [7:0] epc, input logic [1:0] exp_st, input logic exp_pass);
        int n;
        end_pc = epc;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (cpu_hold_a === 1'b0 && n < 200) begin tick(); n++; end
        total++; if (n !== 50) begin bad++; $display("FAIL to_run_len epc=%0h got=%0d want=50", epc, n); end
        total++; if (status_a !== exp_st) begin bad++; $display("FAIL to_status epc=%0h got=%0b want=%0b", epc, status_a, exp_st); end
        total++; if (cycles_a !== 32'd50) begin bad++; $display("FAIL to_cycles epc=%0h got=%0d want=50", epc, cycles_a); end
        dump_ready = 1'b1;
        n = 0;
        while (done_a !== 1'b1 && n < 60) begin tick(); n++; end
        dump_ready = 1'b0;
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL to_done epc=%0h got=0 want=1", epc); end
        total++; if (checksum_a !== 32'd5) begin bad++; $display("FAIL to_checksum epc=%0h got=%0h want=5", epc, checksum_a); end
        total++; if (pass_a !== exp_pass) begin bad++; $display("FAIL to_pass epc=%0h got=%0b want=%0b", epc, pass_a, exp_pass); end
    endtask

    task automatic test_reset_mid_dump;
        int n;
        end_pc = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (cpu_hold_a === 1'b0 && n < 200) begin tick(); n++; end
        dump_ready = 1'b1;
        repeat (7) tick();
        total++; if (dump_valid_a !== 1'b0 || dump_addr_a !== 8'h08 || checksum_a !== 32'd3) begin bad++; $display("FAIL mid_wait valid=%0b addr=%0h sum=%0h want=0,8,3", dump_valid_a, dump_addr_a, checksum_a); end
        rst_n = 1'b0;
        dump_ready = 1'b0;
        tick();
        total++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL mid_rst_flags done=%0b busy=%0b want=0,0", done_a, busy_a); end
        total++; if (checksum_a !== 32'd0 || checksum_b !== 32'd0) begin bad++; $display("FAIL mid_rst_sum got=%0h,%0h want=0,0", checksum_a, checksum_b); end
        total++; if (cpu_rst_n_a !== 1'b0 || cpu_hold_a !== 1'b1 || dump_valid_a !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl rst_n=%0b hold=%0b valid=%0b want=0,1,0", cpu_rst_n_a, cpu_hold_a, dump_valid_a); end
        total++; if (status_a !== 2'b00 || cycles_a !== 32'd0) begin bad++; $display("FAIL mid_rst_cnt st=%0b cyc=%0d want=0,0", status_a, cycles_a); end
        total++; if (dump_addr_a !== 8'd0 || dump_data_a !== 32'd0) begin bad++; $display("FAIL mid_rst_dump addr=%0h data=%0h want=0,0", dump_addr_a, dump_data_a); end
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (cycles_a !== 32'd0 || busy_a !== 1'b1) begin bad++; $display("FAIL rerun_first cyc=%0d busy=%0b want=0,1", cycles_a, busy_a); end
        tick();
        total++; if (cycles_a !== 32'd1) begin bad++; $display("FAIL rerun_second cyc=%0d want=1", cycles_a); end
        n = 0;
        while (cpu_hold_a === 1'b0 && n < 200) begin tick(); n++; end
        total++; if (cycles_a !== 32'd33 || status_a !== 2'b01) begin bad++; $display("FAIL rerun_end cyc=%0d st=%0b want=33,01", cycles_a, status_a); end
        dump_ready = 1'b1;
        n = 0;
        while (done_a !== 1'b1 && n < 60) begin tick(); n++; end
        dump_ready = 1'b0;
        total++; if (done_a !== 1'b1 || checksum_a !== 32'd5 || pass_a !== 1'b1) begin bad++; $display("FAIL rerun_final done=%0b sum=%0h pass=%0b want=1,5,1", done_a, checksum_a, pass_a); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | i;
        mem[8'h00] = 32'd1;
        mem[8'h04] = 32'd2;
        mem[8'h08] = 32'd3;
        mem[8'h0C] = 32'hFFFFFFFF;
        mem[8'hF8] = 32'h10;
        mem[8'hFC] = 32'h20;
        test_reset();
        test_end_pc();
        test_dump();
        test_stall();
        test_timeout(8'h03, 2'b10, 1'b0);
        test_timeout(8'hC4, 2'b01, 1'b1);
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
